fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
Round-robin write-port arbiter for async_fifo. Shares the FIFO write side among NUM_REQ requesters on a valid/ready handshake and tags every word with the source ID. Supports bounded burst lock, so multi-beat packets stay contiguous in the FIFO. Sits entirely in the write clock domain, directly in front of the FIFO wen/wdata/wfull port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
FIFO_WIDTH, 32, FIFO word width
ID_WIDTH, 2, source-ID field width; must equal clog2(NUM_REQ)
MAX_BURST, 8, maximum beats one requester holds the lock (1..256); 1 disables locking

Ports:
wclk  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*(FIFO_WIDTH-ID_WIDTH)  packed payloads; requester k at slice k
req_last  in  NUM_REQ  final beat of packet
req_ready  out  NUM_REQ  per-requester accept
wen  out  1  FIFO write enable
wdata  out  FIFO_WIDTH  {ID, payload}; ID in the MSBs
wfull  in  1  FIFO full, wclk domain
grant_id  out  ID_WIDTH  ID of the most recently written beat
locked  out  1  arbiter in LOCK state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, grant_id=0, locked=0. req_ready=0 and wen=0 while rst_n=0.
- Zero-latency datapath:
  - wen, wdata and req_ready are combinational from registered state plus the inputs.
  - A beat transfers in the cycle where req_valid[k] & req_ready[k]. In that same cycle wen=1 and wdata={k, payload_k}.
  - wen is never 1 while wfull=1. All req_ready are 0 while wfull=1.
  - Exactly one req_ready is high at most; it is high only for the selected k.
- IDLE:
  - sel = first k with req_valid[k]=1, searching k=rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - If no valid: wen=0 and no state change.
  - On transfer with req_last=1, or MAX_BURST=1: stay IDLE, rr_ptr<=sel+1 (mod NUM_REQ).
  - On transfer with req_last=0 and MAX_BURST>1: go to LOCK, owner<=sel, beat_cnt<=1.
- LOCK:
  - Only owner is eligible. Other requesters see req_ready=0 even if the owner is idle.
  - Owner valid=0 inserts a bubble: stay LOCK, counters hold.
  - On transfer: beat_cnt<=beat_cnt+1.
  - Exit to IDLE when req_last=1 or beat_cnt+1==MAX_BURST. On exit: rr_ptr<=owner+1, beat_cnt<=0.
  - A forced exit at MAX_BURST without last splits the packet. The remaining beats re-arbitrate normally.
- grant_id updates to the transferring ID on every transfer and holds otherwise. locked=1 exactly in LOCK.
- wfull stalls hold all state. A stall in LOCK does not count toward MAX_BURST.
- Wrap-around: the rr_ptr and owner+1 increments wrap modulo NUM_REQ. Non-power-of-2 NUM_REQ must wrap at NUM_REQ-1 to 0.
- Simultaneous events:
  - wfull rising in the same cycle as a valid: no transfer.
  - wfull dropping: transfer allowed that cycle.
- Reset mid-burst: immediate return to IDLE. The partial packet in the FIFO is left as is, and requesters restart their packets.
- Requester contract: req_data and req_last are stable while req_valid=1 and not accepted.

Test Plan:
- Reset: rst_n=0 with all req_valid=1 -> wen=0, req_ready=0, grant_id=0, locked=0. After release, first write is {ID 0, data0}.
- Fairness: all 4 requesters continuously valid with req_last=1 on every beat, wfull=0 -> wdata IDs 0,1,2,3,0,1,... with wen high every wclk.
- Burst lock: req1 sends a 3-beat packet (last on beat 3) while req0/req2 are valid -> three consecutive ID-1 words, locked=1 for 2 cycles, next grant ID 2.
- MAX_BURST=8: req3 sends 12 beats with last only on beat 12, others valid -> 8 ID-3 words, then ID 0, then ID 1 and the remaining req3 beats by round robin.
- Backpressure: force wfull=1 for 5 cycles in the middle of a burst -> wen=0 and req_ready=0 throughout, beat_cnt unchanged; burst resumes with no lost or duplicated words. Scoreboard checks the FIFO read side in order per ID.
- Mid-burst reset: assert rst_n=0 after beat 2 of a 5-beat req2 packet -> locked=0 at once; after release, req0 is granted first when all are valid.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter in front of an async FIFO write side.
// Tags each word with its source ID and can lock one requester for a bounded multi-beat burst.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int MAX_BURST  = 8
) (
  input  logic                                    wclk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ*(FIFO_WIDTH-ID_WIDTH)-1:0] req_data,
  input  logic [NUM_REQ-1:0]                      req_last,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic                                    wen,
  output logic [FIFO_WIDTH-1:0]                   wdata,
  input  logic                                    wfull,
  output logic [ID_WIDTH-1:0]                     grant_id,
  output logic                                    locked
);

  localparam int PW    = FIFO_WIDTH - ID_WIDTH;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [ID_WIDTH:0]   NUM_REQ_X = (ID_WIDTH + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0]    BURST_END = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] owner;
  logic [CNT_W-1:0]    beat_cnt;

  logic [PW-1:0]       payload [NUM_REQ];
  logic [NUM_REQ-1:0]  rotated;
  logic [ID_WIDTH-1:0] offset;
  logic [ID_WIDTH:0]   sel_sum;
  logic [ID_WIDTH-1:0] sel;
  logic [ID_WIDTH-1:0] cur;
  logic                cur_valid;
  logic                cur_last;
  logic                xfer;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_payload
    assign payload[gi] = req_data[gi*PW +: PW];
  end

  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // Rotate the valid vector so bit 0 is the requester at rr_ptr; lowest set bit wins.
  assign rotated = NUM_REQ'({req_valid, req_valid} >> rr_ptr);

  always_comb begin
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = i[ID_WIDTH-1:0];
      end
    end
  end

  assign sel_sum = {1'b0, rr_ptr} + {1'b0, offset};
  assign sel     = (sel_sum >= NUM_REQ_X) ? ID_WIDTH'(sel_sum - NUM_REQ_X) : ID_WIDTH'(sel_sum);

  assign cur       = (state == LOCK) ? owner : sel;
  assign cur_valid = (state == LOCK) ? req_valid[owner] : (|req_valid);
  assign cur_last  = req_last[cur];
  assign xfer      = rst_n & ~wfull & cur_valid;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[cur] = 1'b1;
    end
  end

  assign wen   = xfer;
  assign wdata = {cur, payload[cur]};

  // Stalls (wfull or owner bubble) leave every register untouched, so they never count as beats.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
    end else if (xfer) begin
      grant_id <= cur;
      case (state)
        IDLE: begin
          if (cur_last || (MAX_BURST == 1)) begin
            rr_ptr <= next_id(sel);
          end else begin
            state    <= LOCK;
            locked   <= 1'b1;
            owner    <= sel;
            beat_cnt <= CNT_W'(1);
          end
        end
        LOCK: begin
          if (cur_last || (beat_cnt == BURST_END)) begin
            state    <= IDLE;
            locked   <= 1'b0;
            rr_ptr   <= next_id(owner);
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized scoreboard bench for fifo_wr_arb against a behavioural arbitration model.
module tb_fifo_wr_arb;
  localparam int N  = 4;
  localparam int FW = 32;
  localparam int IW = 2;
  localparam int MB = 8;
  localparam int PW = FW - IW;

  logic              wclk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*PW-1:0]   req_data = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_ready;
  logic              wen;
  logic [FW-1:0]     wdata;
  logic              wfull = 1'b0;
  logic [IW-1:0]     grant_id;
  logic              locked;

  fifo_wr_arb #(
    .NUM_REQ(N), .FIFO_WIDTH(FW), .ID_WIDTH(IW), .MAX_BURST(MB)
  ) dut (
    .wclk(wclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wen(wen), .wdata(wdata),
    .wfull(wfull), .grant_id(grant_id), .locked(locked)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic          wen;
    logic [N-1:0]  ready;
    logic          locked;
    logic [IW-1:0] gid;
  } cyc_t;

  logic [FW-1:0] exp_words[$];
  cyc_t          exp_cyc[$];
  int tests = 0;
  int fails = 0;

  // Behavioural model: who holds the port, how many beats taken, where the search starts.
  int m_owner = -1;
  int m_beats = 0;
  int m_rr    = 0;
  int m_gid   = 0;

  // Requester generators.
  int            pkt_len[N];
  int            beat[N];
  logic [PW-1:0] pay[N];
  bit            v[N];
  bit            lst[N];

  int p_valid   = 100;
  int p_full    = 0;
  int max_len   = 4;
  bit all_last  = 1'b1;
  int full_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int predict();
    if (!rst_n || wfull) return -1;
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_xfer(input int k, input bit last);
    m_gid = k;
    if (m_owner < 0) begin
      if (last || MB == 1) m_rr = (k + 1) % N;
      else begin
        m_owner = k;
        m_beats = 1;
      end
    end else begin
      m_beats++;
      if (last || m_beats == MB) begin
        m_rr    = (k + 1) % N;
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  task automatic step(input bit rst_val);
    cyc_t c;
    int   k;
    @(posedge wclk);
    #1;
    rst_n = rst_val;
    if (!rst_val) begin
      m_owner = -1; m_beats = 0; m_rr = 0; m_gid = 0;
      for (int j = 0; j < N; j++) begin
        v[j] = 1'b0;
        beat[j] = 0;
      end
    end
    if (p_full == 0) wfull = 1'b0;
    else if (full_left > 0) begin
      wfull = 1'b1;
      full_left--;
    end else if ($urandom_range(99) < p_full) begin
      full_left = $urandom_range(5, 0);
      wfull = 1'b1;
    end else wfull = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!v[j] && $urandom_range(99) < p_valid) begin
        if (beat[j] == 0) pkt_len[j] = all_last ? 1 : $urandom_range(max_len, 1);
        v[j]   = 1'b1;
        pay[j] = PW'($urandom);
        lst[j] = all_last || (beat[j] == pkt_len[j] - 1);
      end
      req_valid[j]           = v[j];
      req_last[j]            = lst[j];
      req_data[j*PW +: PW]   = pay[j];
    end
    c.locked = (m_owner >= 0);
    c.gid    = IW'(m_gid);
    k = predict();
    c.wen   = (k >= 0);
    c.ready = (k >= 0) ? N'(1 << k) : '0;
    exp_cyc.push_back(c);
    if (k >= 0) begin
      exp_words.push_back({IW'(k), pay[k]});
      model_xfer(k, lst[k]);
      v[k] = 1'b0;
      beat[k] = lst[k] ? 0 : beat[k] + 1;
    end
  endtask

  always @(negedge wclk) begin
    if (exp_cyc.size() != 0) begin
      cyc_t c;
      c = exp_cyc.pop_front();
      check("wen", 64'(wen), 64'(c.wen));
      check("req_ready", 64'(req_ready), 64'(c.ready));
      check("locked", 64'(locked), 64'(c.locked));
      check("grant_id", 64'(grant_id), 64'(c.gid));
      if (wen) begin
        if (exp_words.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wdata: got %0h required no write", wdata);
        end else begin
          check("wdata", 64'(wdata), 64'(exp_words.pop_front()));
        end
      end
    end
  end

  initial begin
    int n_rst;
    n_rst = 0;
    for (int j = 0; j < N; j++) begin
      pkt_len[j] = 1; beat[j] = 0; v[j] = 1'b0; lst[j] = 1'b0; pay[j] = '0;
    end
    // Reset held with every requester valid, then round-robin single-beat fairness.
    p_valid = 100; all_last = 1'b1; p_full = 0;
    repeat (4) step(1'b0);
    repeat (40) step(1'b1);
    // Back-to-back multi-beat packets up to 12 beats, exercising lock and forced split.
    all_last = 1'b0; max_len = 12;
    repeat (300) step(1'b1);
    // Sparse traffic, random wfull runs and occasional mid-burst resets.
    p_valid = 60; p_full = 15;
    for (int i = 0; i < 3000; i++) begin
      if (m_owner >= 0 && m_beats == 2 && n_rst < 6 && $urandom_range(3) == 0) begin
        n_rst++;
        step(1'b0);
      end else begin
        step(1'b1);
      end
    end
    @(negedge wclk);
    #1;
    check("words_left", 64'(exp_words.size()), 64'd0);
    check("cycles_left", 64'(exp_cyc.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
